// File: rtl/muldiv_hilo.sv
// HI/LO register unit that sequences an external signed multiplier for MULT/MULTU and
// handles MTHI/MTLO writes; MULTU is derived from the signed product by a high-word fixup.
module muldiv_hilo #(
  parameter bit MULTU_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  output logic        o_mul_start,
  input  logic [63:0] i_mul_z,
  input  logic        i_mul_done,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StFix,
    StWb
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_uns;
  logic [63:0] r_prod;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_start;

  logic        w_is_mul;
  logic [31:0] w_fix_add;

  assign w_is_mul  = (i_op == 3'd1) || (i_op == 3'd2);
  // Signed-to-unsigned correction of the high word, modulo 2^32.
  assign w_fix_add = (r_a[31] ? r_b : 32'd0) + (r_b[31] ? r_a : 32'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_uns   <= 1'b0;
      r_prod  <= 64'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_start <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_is_mul) begin
            r_a     <= i_rs;
            r_b     <= i_rt;
            r_uns   <= (i_op == 3'd2) && MULTU_EN;
            r_start <= 1'b1;
            r_state <= StArm;
          end else if (i_op == 3'd3) begin
            r_hi <= i_rs;
          end else if (i_op == 3'd4) begin
            r_lo <= i_rs;
          end
        end
        // A done still high from the previous operation must be seen low first.
        StArm: begin
          if (!i_mul_done) r_state <= StWait;
        end
        StWait: begin
          if (i_mul_done) begin
            r_prod  <= i_mul_z;
            r_start <= 1'b0;
            r_state <= StFix;
          end
        end
        StFix: begin
          if (r_uns) r_prod[63:32] <= r_prod[63:32] + w_fix_add;
          r_state <= StWb;
        end
        StWb: begin
          r_hi    <= r_prod[63:32];
          r_lo    <= r_prod[31:0];
          r_state <= StIdle;
        end
        default: begin
          r_start <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_mul_a     = r_a;
  assign o_mul_b     = r_b;
  assign o_mul_start = r_start;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  // The requesting instruction stalls from its first cycle.
  assign o_busy      = (r_state != StIdle) || w_is_mul;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: behavioural multiplier with random latency and stale done,
// an arithmetic reference of HI/LO, per-cycle compare, and literal anchor cases.
module tb_muldiv_hilo;

  localparam bit MULTU_EN = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_start;
  logic [63:0] mul_z = 64'd0;
  logic        mul_done = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail = 0;
  logic run_chk = 1'b0;

  muldiv_hilo #(.MULTU_EN(MULTU_EN)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_op       (op),
    .i_rs       (rs),
    .i_rt       (rt),
    .o_mul_a    (mul_a),
    .o_mul_b    (mul_b),
    .o_mul_start(mul_start),
    .i_mul_z    (mul_z),
    .i_mul_done (mul_done),
    .o_busy     (busy),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Multiplier stand-in: done updates on the falling edge and stays high until the next start.
  logic        mm_active = 1'b0;
  logic        mm_prev = 1'b0;
  int          mm_clr = 0;
  int          mm_lat = 0;
  logic [63:0] mm_prod = 64'd0;

  always @(negedge clk) begin
    mm_prev <= mul_start;
    if (reset) begin
      mul_done  <= 1'b0;
      mm_active <= 1'b0;
    end else if (!mm_active) begin
      if (mul_start && !mm_prev) begin
        mm_active <= 1'b1;
        mm_clr    <= int'($urandom_range(0, 2));
        mm_lat    <= int'($urandom_range(1, 8));
        mm_prod   <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
      end
    end else if (mm_clr > 0) begin
      mm_clr <= mm_clr - 1;
    end else if (mm_lat > 0) begin
      mul_done <= 1'b0;
      mm_lat   <= mm_lat - 1;
    end else begin
      mul_done  <= 1'b1;
      mul_z     <= mm_prod;
      mm_active <= 1'b0;
    end
  end

  // Reference: result computed arithmetically at issue, landed two edges after done is taken.
  logic        m_pend = 1'b0;
  int          m_phase = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic [63:0] m_res = 64'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend <= 1'b0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_a    <= 32'd0;
      m_b    <= 32'd0;
    end else if (!m_pend) begin
      if (op == 3'd1 || op == 3'd2) begin
        m_pend  <= 1'b1;
        m_phase <= 0;
        m_a     <= rs;
        m_b     <= rt;
        if (op == 3'd2 && MULTU_EN) m_res <= {32'd0, rs} * {32'd0, rt};
        else m_res <= {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
      end else if (op == 3'd3) begin
        m_hi <= rs;
      end else if (op == 3'd4) begin
        m_lo <= rs;
      end
    end else begin
      case (m_phase)
        0: if (!mul_done) m_phase <= 1;
        1: if (mul_done) m_phase <= 2;
        2: m_phase <= 3;
        default: begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_pend <= 1'b0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (run_chk) begin
      chk("hi", {32'd0, hi}, {32'd0, m_hi});
      chk("lo", {32'd0, lo}, {32'd0, m_lo});
      chk("busy", {63'd0, busy}, {63'd0, m_pend || op == 3'd1 || op == 3'd2});
      chk("mul_start", {63'd0, mul_start}, {63'd0, m_pend && m_phase <= 1});
      if (m_pend) begin
        chk("mul_a", {32'd0, mul_a}, {32'd0, m_a});
        chk("mul_b", {32'd0, mul_b}, {32'd0, m_b});
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (m_pend && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (m_pend) chk({nm, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    #2;
    op = o;
    rs = a;
    rt = b;
    @(negedge clk);
    #2;
    op = 3'd0;
  endtask

  task automatic mul_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    wait_idle(nm);
    issue(o, a, b);
    @(posedge clk);
    #1;
    wait_idle(nm);
    chk({nm, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({nm, "_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #12;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_start", {63'd0, mul_start}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    run_chk = 1'b1;

    mul_op("mult_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    mul_op("multu_ffxff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    mul_op("mult_ffxff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    mul_op("multu_8x8", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    mul_op("mult_8x8", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    // Second multiply starts while done is still high from the first.
    mul_op("b2b_first", 3'd1, 32'd7, 32'd6, 32'h0, 32'h2A);
    mul_op("b2b_second", 3'd1, 32'd5, 32'd5, 32'h0, 32'h19);

    @(negedge clk);
    #2;
    op = 3'd3;
    rs = 32'h1234_5678;
    @(negedge clk);
    #2;
    op = 3'd4;
    rs = 32'h9ABC_DEF0;
    @(negedge clk);
    #2;
    op = 3'd0;
    chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    chk("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);

    // Abort a multiply with reset while waiting on the multiplier.
    issue(3'd1, 32'd3, 32'd3);
    begin
      int n = 0;
      while (m_phase != 1 && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_start", {63'd0, mul_start}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    mul_op("after_abort", 3'd1, 32'd3, 32'd3, 32'h0, 32'h9);

    // MTHI while busy is ignored; the multiply result lands.
    issue(3'd1, 32'hFFFF_FFFF, 32'd5);
    op = 3'd3;
    rs = 32'hDEAD_BEEF;
    @(negedge clk);
    #2;
    op = 3'd0;
    chk("mthi_busy_hi", {32'd0, hi}, 64'h0);
    wait_idle("mthi_busy");
    chk("mthi_busy_wb_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("mthi_busy_wb_lo", {32'd0, lo}, 64'hFFFF_FFFB);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #2;
      op = 3'($urandom_range(0, 7));
      rs = pick();
      rt = pick();
      reset = (i % 400 == 399);
    end
    @(negedge clk);
    #2;
    op = 3'd0;
    reset = 1'b0;
    wait_idle("final");
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
